// File: rtl/chest_pkg.sv
// Shared definitions for the channel-estimation interpolation datapath:
// FSM encoding, mode constants and the output-width legality check.
package chest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic MODE_INTERP = 1'b0;
  localparam logic MODE_EXTRAP = 1'b1;

  // Output must hold STEPS*Ea plus (STEPS-1)*|D| without wrapping.
  function automatic bit width_ok(input int in_w, input int out_w, input int steps);
    return (steps >= 2) && (steps <= 16) && (out_w >= in_w + $clog2(steps) + 2);
  endfunction

endpackage

// File: rtl/interp_lane_acc.sv
// One lane of the interpolator: holds the captured pilots, the difference D
// and the running accumulator that walks from STEPS*Ea in steps of +/-D.
module interp_lane_acc #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 22,
  parameter int STEPS     = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic                        prep,
  input  logic                        step,
  input  logic                        sub,
  input  logic signed [IN_WIDTH-1:0]  ea,
  input  logic signed [IN_WIDTH-1:0]  eb,
  output logic signed [OUT_WIDTH-1:0] acc
);

  logic signed [IN_WIDTH-1:0]  ea_q, ea_d, eb_q, eb_d;
  logic signed [OUT_WIDTH-1:0] d_q, d_d, acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] ea_ext, eb_ext, scaled;

  assign ea_ext = {{(OUT_WIDTH-IN_WIDTH){ea_q[IN_WIDTH-1]}}, ea_q};
  assign eb_ext = {{(OUT_WIDTH-IN_WIDTH){eb_q[IN_WIDTH-1]}}, eb_q};

  // STEPS is a constant, so this unrolls into a fixed shift-add tree.
  always_comb begin
    scaled = '0;
    for (int i = 0; i < 5; i++) begin
      if (((STEPS >> i) & 1) == 1) scaled = scaled + (ea_ext <<< i);
    end
  end

  always_comb begin
    ea_d  = ea_q;
    eb_d  = eb_q;
    d_d   = d_q;
    acc_d = acc_q;
    if (capture) begin
      ea_d = ea;
      eb_d = eb;
    end
    if (prep) begin
      d_d   = eb_ext - ea_ext;
      acc_d = scaled;
    end else if (step) begin
      acc_d = sub ? (acc_q - d_q) : (acc_q + d_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q  <= '0;
      eb_q  <= '0;
      d_q   <= '0;
      acc_q <= '0;
    end else begin
      ea_q  <= ea_d;
      eb_q  <= eb_d;
      d_q   <= d_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/interp_seq_add.sv
// Sequenced multiplier-free interpolator: accepts Ea/Eb per lane and streams
// STEPS outputs STEPS*Ea +/- k*(Eb-Ea); downstream divides by STEPS.
module interp_seq_add
  import chest_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 22,
  parameter int STEPS     = 7,
  parameter int LANES     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [LANES*IN_WIDTH-1:0]    ea,
  input  logic [LANES*IN_WIDTH-1:0]    eb,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(STEPS)-1:0]     out_k,
  output logic                         out_last
);

  localparam int K_W = $clog2(STEPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(STEPS - 1);

  if (!width_ok(IN_WIDTH, OUT_WIDTH, STEPS)) begin : g_bad_params
    $error("interp_seq_add: OUT_WIDTH too small or STEPS out of 2..16");
  end

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic [K_W-1:0] k_q, k_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           capture, prep, step;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid never depends combinationally on out_ready.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    capture     = 1'b0;
    prep        = 1'b0;
    step        = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            capture    = 1'b1;
            mode_d     = mode;
            in_ready_d = 1'b0;
            state_d    = ST_PREP;
          end
        end
        ST_PREP: begin
          prep        = 1'b1;
          k_d         = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          if (out_ready) begin
            if (k_q == K_LAST) begin
              state_d     = ST_IDLE;
              in_ready_d  = 1'b1;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              step       = 1'b1;
              k_d        = k_q + 1'b1;
              out_last_d = (k_d == K_LAST);
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_INTERP;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    interp_lane_acc #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .STEPS     (STEPS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .capture (capture),
      .prep    (prep),
      .step    (step),
      .sub     (mode_q == MODE_EXTRAP),
      .ea      (ea[l*IN_WIDTH +: IN_WIDTH]),
      .eb      (eb[l*IN_WIDTH +: IN_WIDTH]),
      .acc     (out_data[l*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_k     = k_q;

endmodule

// File: tb/tb_interp_seq_add.sv
// Directed and randomized jobs for interp_seq_add, checked against an
// arithmetic model of y_k = STEPS*Ea +/- k*(Eb-Ea) per lane.
module tb_interp_seq_add;

  localparam int IW = 17;
  localparam int OW = 22;
  localparam int ST = 7;
  localparam int LN = 2;
  localparam int KW = $clog2(ST);

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [LN*IW-1:0]  ea;
  logic [LN*IW-1:0]  eb;
  logic              out_valid;
  logic              out_ready;
  logic [LN*OW-1:0]  out_data;
  logic [KW-1:0]     out_k;
  logic              out_last;

  int vectors = 0;
  int errors  = 0;
  logic [LN*OW-1:0] exp_q[$];

  interp_seq_add #(
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .STEPS     (ST),
    .LANES     (LN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .ea        (ea),
    .eb        (eb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_k     (out_k),
    .out_last  (out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_k"},     out_k, 0);
  endtask

  function automatic int rand_pilot();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  // Reference model: the whole job's output sequence by plain arithmetic.
  task automatic build_expected(input int a0, input int b0, input int a1,
                                input int b1, input logic md);
    int y0, y1, sgn;
    exp_q.delete();
    sgn = md ? -1 : 1;
    for (int k = 0; k < ST; k++) begin
      y0 = ST * a0 + sgn * k * (b0 - a0);
      y1 = ST * a1 + sgn * k * (b1 - a1);
      exp_q.push_back({OW'(y1), OW'(y0)});
    end
  endtask

  task automatic start_job(input int a0, input int b0, input int a1,
                           input int b1, input logic md);
    check("accept_in_ready", in_ready, 1);
    in_valid = 1'b1;
    ea       = {IW'(a1), IW'(a0)};
    eb       = {IW'(b1), IW'(b0)};
    mode     = md;
    @(negedge clk);
    in_valid = 1'b0;
    check("prep_out_valid", out_valid, 0);
    check("prep_in_ready", in_ready, 0);
    @(negedge clk);
    check("first_valid_latency", out_valid, 1);
  endtask

  // policy 0: ready always high, 1: random ready, 2: stall 3 cycles at k=2
  task automatic run_job(input int a0, input int b0, input int a1, input int b1,
                         input logic md, input int policy, input bit poke);
    int k_exp, budget, stall;
    logic rdy;
    logic [LN*OW-1:0] e;
    build_expected(a0, b0, a1, b1, md);
    start_job(a0, b0, a1, b1, md);
    k_exp = 0; budget = 0; stall = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      budget++;
      e = exp_q[0];
      check("run_out_valid", out_valid, 1);
      check("lane0_data", $signed(out_data[OW-1:0]), $signed(e[OW-1:0]));
      check("lane1_data", $signed(out_data[2*OW-1:OW]), $signed(e[2*OW-1:OW]));
      check("out_k", out_k, k_exp);
      check("out_last", out_last, (k_exp == ST - 1));
      case (policy)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(k_exp == 2 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      out_ready = rdy;
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        ea       = {IW'(rand_pilot()), IW'(rand_pilot())};
        eb       = {IW'(rand_pilot()), IW'(rand_pilot())};
      end
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        k_exp++;
      end
    end
    check("job_drained", exp_q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("end_in_ready", in_ready, 1);
    check("end_out_valid", out_valid, 0);
    check("end_out_last", out_last, 0);
    @(negedge clk);
    check("idle_stays_valid_low", out_valid, 0);
    check("idle_stays_ready", in_ready, 1);
  endtask

  initial begin
    int found;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mode = 1'b0;
    ea = '0; eb = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // interpolate / extrapolate, lane1 held constant with D=0
    run_job(10, 24, -8, -8, 1'b0, 0, 1'b0);
    run_job(10, 24, -8, -8, 1'b1, 0, 1'b0);
    // negative and extreme pilots
    run_job(-5, 3, 65535, -65536, 1'b0, 0, 1'b0);
    run_job(-65536, 65535, 65535, -65536, 1'b0, 0, 1'b0);
    run_job(-65536, 65535, -65536, 65535, 1'b1, 0, 1'b0);
    // backpressure at k=2
    run_job(10, 24, -8, -8, 1'b0, 2, 1'b0);
    // in_valid poked during RUN must be ignored
    run_job(10, 24, -8, -8, 1'b0, 0, 1'b1);

    // flush at k=3
    build_expected(10, 24, -8, -8, 1'b0);
    start_job(10, 24, -8, -8, 1'b0);
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (out_valid && out_k == 3) found = 1;
      else @(negedge clk);
    end
    check("flush_reached_k3", out_k, 3);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(negedge clk);
    check("flush_ignored_in_valid", in_ready, 1);
    check("flush_still_idle", out_valid, 0);
    exp_q.delete();
    run_job(-5, 3, -8, -8, 1'b0, 0, 1'b0);

    // async reset mid-RUN
    build_expected(10, 24, 100, -200, 1'b0);
    start_job(10, 24, 100, -200, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("after_async_reset");
    run_job(10, 24, -8, -8, 1'b1, 0, 1'b0);

    // randomized jobs with random backpressure and pokes
    for (int j = 0; j < 8; j++) begin
      run_job(rand_pilot(), rand_pilot(), rand_pilot(), rand_pilot(),
              1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/interp_seq_add.md
Name: interp_seq_add

Overview:
- Sequenced, multiplier-free operand/adder datapath for time-domain interpolation of NRS channel estimates in the channel-estimation chain.
- Accepts two pilot estimates per lane (Ea, Eb), forms D = Eb - Ea once, then streams STEPS scaled outputs y_k = STEPS*Ea +/- k*D by repeated accumulation.
- Generalised successor to the fixed 3-bit operand-mux stage: parametrised width, step count and lane count, with an extrapolation mode and a valid/ready handshake.
- Sits between pilot LS estimation and the equaliser; the downstream block applies the 1/STEPS scaling.

Parameters:
- IN_WIDTH, 17, signed width of each pilot estimate.
- OUT_WIDTH, 22, signed output width. Must be >= IN_WIDTH + clog2(STEPS) + 2; an elaboration check fails otherwise.
- STEPS, 7, number of outputs per job; range 2..16.
- LANES, 2, parallel lanes (I/Q). All lanes share control.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort to IDLE.
- in_valid  in  1  job request.
- in_ready  out  1  high only in IDLE.
- mode  in  1  0 = interpolate (+D), 1 = extrapolate backwards (-D). Sampled on job accept.
- ea  in  LANES*IN_WIDTH  packed signed Ea, lane 0 in the LSBs.
- eb  in  LANES*IN_WIDTH  packed signed Eb.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*OUT_WIDTH  packed signed y_k.
- out_k  out  clog2(STEPS)  current step index k.
- out_last  out  1  high with k = STEPS-1.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - in_ready = 1; out_valid = 0; out_last = 0.
  - out_data = 0; out_k = 0.
  - Internal D and accumulator registers = 0.
- FSM states: IDLE, PREP, RUN.
- IDLE:
  - in_ready = 1.
  - On in_valid, register ea, eb and mode, then go to PREP.
- PREP (1 cycle):
  - D = eb - ea, sign-extended to OUT_WIDTH.
  - acc = STEPS*ea, built as a constant shift-add of the sign-extended ea.
  - k = 0. Go to RUN.
- RUN:
  - out_valid = 1; out_data = acc; out_k = k.
  - On out_valid & out_ready:
    - If k < STEPS-1: acc <= acc + D (mode 0) or acc - D (mode 1), and k <= k+1.
    - If k = STEPS-1: go to IDLE.
  - If out_ready is low, out_data, out_k and out_last hold stable.
- Latency and throughput:
  - Job accepted at cycle 0; first out_valid at cycle 2.
  - With out_ready held high: one output per cycle, last output at cycle STEPS+1, in_ready high again at cycle STEPS+2.
- All outputs are registered; there is no combinational path from out_ready to out_valid.
- Arithmetic:
  - Two's complement throughout.
  - The width rule guarantees no overflow for any in-range inputs, so there is no saturation logic.
- flush:
  - Has priority over all handshakes.
  - Next cycle: state = IDLE, out_valid = 0, in_ready = 1. Any in_valid asserted in the same cycle is ignored.
- rst asserted mid-job: immediate async return to reset values; the job is discarded.
- in_valid while not in IDLE: ignored; in_ready is low, so nothing is accepted.

Decomposition:
- Shared package (chest_pkg):
  - State encoding localparams (IDLE = 2'b00, PREP = 2'b01, RUN = 2'b10).
  - MODE_INTERP / MODE_EXTRAP constants.
  - Width-check function.
- One natural sub-module: interp_lane_acc.
  - Per-lane registered D/accumulator: sign-extend, constant STEPS*ea shift-add, +/- D.
  - Instantiated LANES times via generate.
- The FSM and handshake logic live in the top module.

Test Plan:
1. STEPS=7, mode 0, lane0 Ea=10, Eb=24, out_ready=1.
   - out_data lane0 = 70, 84, 98, 112, 126, 140, 154.
   - out_last with k=6; first valid 2 cycles after accept.
2. Mode 1, same inputs.
   - 70, 56, 42, 28, 14, 0, -14.
3. Negative and extreme values.
   - Ea=-5, Eb=3 -> -35, -27, ..., 13.
   - Ea=-65536, Eb=65535 -> final value 327674, no wrap.
4. Backpressure: out_ready low for 3 cycles at k=2.
   - out_data = 98 and out_k = 2 held stable.
   - Sequence resumes with no lost or duplicated samples.
5. Abort and reset:
   - flush at k=3 -> out_valid = 0 and in_ready = 1 next cycle.
   - A new job then runs normally.
   - rst pulse mid-RUN -> all outputs return to reset values immediately.
6. LANES=2 independence: lane1 Ea=-8, Eb=-8 (D=0).
   - lane1 outputs are constant -56 while lane0 runs scenario 1.
   - in_valid pulsed during RUN is ignored.
